// File: rtl/imem_boot_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_boot_ctrl_if
// Loader word stream into the instruction-memory boot controller.
//   ld_valid  loader -> controller  word valid
//   ld_data   loader -> controller  instruction word
//   ld_ready  controller -> loader  word accepted this cycle
// master = loader, slave = boot controller.
// ---------------------------------------------------------------------------
interface imem_boot_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  modport master (output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/imem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// imem_boot_ctrl
// Boots a program into instruction memory from a loader stream, then hands
// the memory read port to the CPU and traps out-of-range PCs.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load_start        one-cycle load request, load_len sampled with it
//   load_len          words to load (clamped to 2^ADDR_W, 0 ignored)
//   ld                loader stream (ld_valid/ld_data/ld_ready), slave side
//   cpu_pc            CPU word address
//   mem_rdata         combinational read data from instruction memory
//   mem_addr/we/wdata instruction-memory address and write port
//   instr, cpu_stall  instruction to CPU and CPU hold request
//   busy, done, fault load in progress, load-complete pulse, sticky PC fault
//   words_loaded      words written by the most recent load
// ---------------------------------------------------------------------------
module imem_boot_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  imem_boot_ctrl_if.slave   ld,
  input  logic [31:0]       cpu_pc,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;
  logic              done_q;
  logic              fault_q;

  logic [ADDR_W:0]   clamped_len;
  logic              start_load;
  logic              pc_oob;
  logic              handshake;
  logic              last_word;

  // A load may start from any state except LOAD itself; zero-length requests
  // are dropped so the CPU is never left waiting on an empty load.
  always_comb begin
    clamped_len = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    start_load  = load_start && (load_len != '0) && (state != LOAD);
    pc_oob      = (cpu_pc[31:ADDR_W] != '0);
    handshake   = (state == LOAD) && ld.ld_valid;
    last_word   = handshake && ((cnt_q + ONE) == len_q);
  end

  // wr_ptr is only ADDR_W bits wide: a full-size load wraps it to 0 on the
  // final word, which is harmless because the FSM leaves LOAD at that point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_load) begin
        state   <= LOAD;
        wr_ptr  <= '0;
        cnt_q   <= '0;
        len_q   <= clamped_len;
        fault_q <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (handshake) begin
              wr_ptr <= wr_ptr + 1'b1;
              cnt_q  <= cnt_q + ONE;
              if (last_word) begin
                state  <= RUN;
                done_q <= 1'b1;
              end
            end
          end
          RUN: begin
            if (pc_oob) begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // All outputs decode straight from state so reset takes effect at once.
  // An out-of-range PC in RUN is squashed to a NOP in the same cycle.
  always_comb begin
    ld.ld_ready = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = wr_ptr;
    mem_wdata   = ld.ld_data;
    instr       = '0;
    cpu_stall   = 1'b1;
    busy        = 1'b0;
    case (state)
      LOAD: begin
        ld.ld_ready = 1'b1;
        busy        = 1'b1;
        mem_we      = ld.ld_valid;
      end
      RUN: begin
        mem_addr = cpu_pc[ADDR_W-1:0];
        if (!pc_oob) begin
          instr     = mem_rdata;
          cpu_stall = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign done         = done_q;
  assign fault        = fault_q;
  assign words_loaded = cnt_q;

endmodule
